aes_inv_subbytes_iter: RTL and testbench

Iterative AES inverse SubBytes stage in the decryption round datapath. It sits directly downstream of the inverse ShiftRows stage and consumes its 128-bit output. The 16 state bytes are substituted through `LANES` inverse S-box instances over `16/LANES` cycles, trading area for latency. A valid/ready handshake on both sides lets it stall against the round-key-addition and inverse MixColumns logic that follows.

---
 rtl/aes_dec_pkg.sv | 22 ++
 rtl/aes_inv_sbox.sv | 32 +++
 rtl/aes_inv_subbytes_iter.sv | 105 ++++++++++
 tb/tb_aes_inv_subbytes_iter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_dec_pkg.sv
// Shared definitions for the AES decryption datapath.
//   AES_NB_BYTES / AES_STATE_W : state size in bytes / bits
//   aes_iter_state_t           : IDLE/RUN/DONE state of the iterative stages
//   lanes_legal()              : legal byte-lane counts for iterative stages
package aes_dec_pkg;

  localparam int AES_NB_BYTES = 16;
  localparam int AES_STATE_W  = AES_NB_BYTES * 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } aes_iter_state_t;

  // The lane count must divide the 16-byte state into equal power-of-two groups.
  function automatic bit lanes_legal(input int lanes);
    return (lanes == 1) || (lanes == 2) || (lanes == 4) ||
           (lanes == 8) || (lanes == 16);
  endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// FIPS-197 inverse S-box, purely combinational.
//   din  : byte to substitute
//   dout : inverse S-box image of din
module aes_inv_sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  // NOTE: this table is a constant lookup, not storage, so it has no reset and
  // no clock; it maps to gates/ROM, never to flops.
  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  assign dout = INV_SBOX[din];

endmodule

// File: rtl/aes_inv_subbytes_iter.sv
// Iterative AES inverse SubBytes. Substitutes LANES bytes per cycle, so a
// full 16-byte state takes 16/LANES RUN cycles.
//   LANES     : inverse S-box instances / bytes per cycle (1, 2, 4, 8, 16)
//   clk, rst  : clock, asynchronous active-high reset
//   in_valid, in_ready, din   : input handshake, byte 0 in din[127:120]
//   out_valid, out_ready, dout: output handshake, same byte order as din
//   busy      : high while a state is being processed or held for output
module aes_inv_subbytes_iter
  import aes_dec_pkg::*;
#(
  parameter int LANES = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] din,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] dout,
  output logic         busy
);

  if (!lanes_legal(LANES)) begin : g_lanes_check
    $error("aes_inv_subbytes_iter: LANES=%0d must be 1, 2, 4, 8 or 16", LANES);
  end

  localparam int N     = AES_NB_BYTES / LANES;
  localparam int GW    = LANES * 8;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  aes_iter_state_t        state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [AES_STATE_W-1:0] st_q, st_d;
  logic [GW-1:0]          grp_in, grp_out;

  // Byte group cnt occupies a contiguous slice, byte cnt*LANES at its top.
  always_comb begin
    grp_in = '0;
    for (int g = 0; g < N; g++) begin
      if (cnt_q == CNT_W'(g)) grp_in = st_q[AES_STATE_W-1-g*GW -: GW];
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    aes_inv_sbox u_sbox (
      .din  (grp_in [GW-1-8*l -: 8]),
      .dout (grp_out[GW-1-8*l -: 8])
    );
  end

  always_comb begin
    // NOTE: every signal driven here gets its default first, so no branch can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    st_d    = st_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          st_d    = din;
        end
      end
      ST_RUN: begin
        for (int g = 0; g < N; g++) begin
          if (cnt_q == CNT_W'(g)) st_d[AES_STATE_W-1-g*GW -: GW] = grp_out;
        end
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      st_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      st_q    <= st_d;
    end
  end

  // Handshake outputs decode registered state only.
  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign dout      = st_q;

endmodule

// File: tb/tb_aes_inv_subbytes_iter.sv
// Self-checking bench: one instance per legal LANES value (index g -> LANES=1<<g).
// The reference inverse S-box is derived from GF(2^8) arithmetic and the
// forward affine map rather than a copied table.
module tb_aes_inv_subbytes_iter;

  localparam int NI = 5;
  localparam logic [127:0] KNOWN_IN  = 128'h637c777bf26b6fc53001672bfed7ab76;
  localparam logic [127:0] KNOWN_OUT = 128'h000102030405060708090a0b0c0d0e0f;

  logic           clk = 1'b0;
  logic           rst;
  logic [127:0]   din;
  logic [NI-1:0]  in_valid_v, out_ready_v, in_ready_v, out_valid_v, busy_v;
  logic [127:0]   dout_v [NI];

  int checks = 0;
  int errors = 0;
  logic [7:0] inv_tab [256];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    aes_inv_subbytes_iter #(.LANES(1 << g)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid_v[g]),
      .in_ready  (in_ready_v[g]),
      .din       (din),
      .out_valid (out_valid_v[g]),
      .out_ready (out_ready_v[g]),
      .dout      (dout_v[g]),
      .busy      (busy_v[g])
    );
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic hi;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  task automatic build_model();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      inv_tab[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] model_inv_sub(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = inv_tab[s[127-8*i -: 8]];
    return r;
  endfunction

  // Byte 4c+r is row r, column c; inverse ShiftRows rotates row r right by r.
  function automatic logic [127:0] model_inv_shift(input logic [127:0] s);
    logic [127:0] r;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        r[127-8*(4*c+w) -: 8] = s[127-8*(4*((c-w+4)%4)+w) -: 8];
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- stimulus helpers (no comparisons) ----------------
  task automatic start(input int idx, input logic [127:0] d);
    din = d;
    in_valid_v[idx] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[idx] = 1'b0;
  endtask

  task automatic wait_valid(input int idx, output int lat);
    lat = 0;
    while (out_valid_v[idx] !== 1'b1 && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic drain(input int idx);
    out_ready_v[idx] = 1'b1;
    @(posedge clk); #1;
    out_ready_v[idx] = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int g = 0; g < NI; g++) begin
      checks++; if (in_ready_v[g] !== 1'b1) begin errors++; $display("FAIL reset_in_ready[%0d]: got %b want 1", g, in_ready_v[g]); end
      checks++; if (out_valid_v[g] !== 1'b0) begin errors++; $display("FAIL reset_out_valid[%0d]: got %b want 0", g, out_valid_v[g]); end
      checks++; if (busy_v[g] !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d]: got %b want 0", g, busy_v[g]); end
      checks++; if (dout_v[g] !== 128'h0) begin errors++; $display("FAIL reset_dout[%0d]: got %h want 0", g, dout_v[g]); end
    end
  endtask

  task automatic test_known_vector();
    int lat;
    checks++; if (in_ready_v[0] !== 1'b1) begin errors++; $display("FAIL known_in_ready: got %b want 1", in_ready_v[0]); end
    start(0, KNOWN_IN);
    checks++; if (busy_v[0] !== 1'b1) begin errors++; $display("FAIL known_busy: got %b want 1", busy_v[0]); end
    wait_valid(0, lat);
    checks++; if (lat != 16) begin errors++; $display("FAIL known_latency: got %0d want 16", lat); end
    checks++; if (dout_v[0] !== KNOWN_OUT) begin errors++; $display("FAIL known_dout: got %h want %h", dout_v[0], KNOWN_OUT); end
    drain(0);
    checks++; if (out_valid_v[0] !== 1'b0 || in_ready_v[0] !== 1'b1) begin
      errors++; $display("FAIL known_release: out_valid=%b in_ready=%b want 0/1", out_valid_v[0], in_ready_v[0]);
    end
  endtask

  task automatic test_uniform();
    int lat;
    logic [127:0] pat, exp;
    for (int g = 0; g < NI; g++) begin
      for (int v = 0; v < 2; v++) begin
        pat = v ? {16{8'hff}} : {16{8'h00}};
        exp = v ? {16{8'h7d}} : {16{8'h52}};
        start(g, pat);
        wait_valid(g, lat);
        checks++; if (lat != (16 >> g)) begin errors++; $display("FAIL uniform_latency[L=%0d,%0d]: got %0d want %0d", 1 << g, v, lat, 16 >> g); end
        checks++; if (dout_v[g] !== exp) begin errors++; $display("FAIL uniform_dout[L=%0d,%0d]: got %h want %h", 1 << g, v, dout_v[g], exp); end
        drain(g);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    start(0, KNOWN_IN);
    wait_valid(0, lat);
    din = {16{8'h00}};
    in_valid_v[0] = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid_v[0] !== 1'b1 || dout_v[0] !== KNOWN_OUT || in_ready_v[0] !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold: out_valid=%b in_ready=%b dout=%h want 1/0/%h", out_valid_v[0], in_ready_v[0], dout_v[0], KNOWN_OUT);
      end
    end
    drain(0);
    checks++; if (in_ready_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || out_valid_v[0] !== 1'b0) begin
      errors++; $display("FAIL bp_idle_after_consume: in_ready=%b busy=%b out_valid=%b want 1/0/0", in_ready_v[0], busy_v[0], out_valid_v[0]);
    end
    @(posedge clk); #1;
    in_valid_v[0] = 1'b0;
    checks++; if (busy_v[0] !== 1'b1) begin errors++; $display("FAIL bp_second_accept: busy=%b want 1", busy_v[0]); end
    wait_valid(0, lat);
    checks++; if (lat != 16) begin errors++; $display("FAIL bp_second_latency: got %0d want 16", lat); end
    checks++; if (dout_v[0] !== {16{8'h52}}) begin errors++; $display("FAIL bp_second_dout: got %h want %h", dout_v[0], {16{8'h52}}); end
    drain(0);
  endtask

  task automatic test_reset_mid_run();
    int lat;
    start(0, KNOWN_IN);
    repeat (7) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++; if (busy_v[0] !== 1'b0 || out_valid_v[0] !== 1'b0 || in_ready_v[0] !== 1'b1) begin
      errors++; $display("FAIL rst_mid_flags: busy=%b out_valid=%b in_ready=%b want 0/0/1", busy_v[0], out_valid_v[0], in_ready_v[0]);
    end
    checks++; if (dout_v[0] !== 128'h0) begin errors++; $display("FAIL rst_mid_dout: got %h want 0", dout_v[0]); end
    din = {16{8'h63}};
    in_valid_v[0] = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy_v[0] !== 1'b0) begin errors++; $display("FAIL rst_no_handshake: busy=%b want 0", busy_v[0]); end
    rst = 1'b0;
    start(0, {16{8'h63}});
    wait_valid(0, lat);
    checks++; if (lat != 16) begin errors++; $display("FAIL rst_next_latency: got %0d want 16", lat); end
    checks++; if (dout_v[0] !== 128'h0) begin errors++; $display("FAIL rst_next_dout: got %h want 0", dout_v[0]); end
    drain(0);
  endtask

  task automatic run_stream(input int idx, input int count, input bit chain, input string name);
    logic [127:0] exp_q [$];
    logic [127:0] raw, exp;
    int n, sent, got, cyc, last_acc;
    bit acc_pending;
    n = 16 >> idx; sent = 0; got = 0; cyc = 0; last_acc = -1;
    raw = rnd128();
    din = chain ? model_inv_shift(raw) : raw;
    in_valid_v[idx]  = 1'b1;
    out_ready_v[idx] = 1'b1;
    acc_pending = in_ready_v[idx];
    while (got < count && cyc < count * (n + 2) + 50) begin
      @(posedge clk); #1;
      cyc++;
      if (acc_pending) begin
        exp_q.push_back(chain ? model_inv_sub(model_inv_shift(raw)) : model_inv_sub(raw));
        if (last_acc >= 0) begin
          checks++; if (cyc - last_acc != n + 2) begin errors++; $display("FAIL %s_period: got %0d want %0d", name, cyc - last_acc, n + 2); end
        end
        last_acc = cyc;
        sent++;
        raw = rnd128();
        din = chain ? model_inv_shift(raw) : raw;
        if (sent == count) in_valid_v[idx] = 1'b0;
      end
      if (out_valid_v[idx] === 1'b1) begin
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        checks++; if (dout_v[idx] !== exp) begin errors++; $display("FAIL %s_dout[%0d]: got %h want %h", name, got, dout_v[idx], exp); end
        got++;
      end
      acc_pending = in_ready_v[idx] && in_valid_v[idx];
    end
    checks++; if (got != count) begin errors++; $display("FAIL %s_count: got %0d want %0d", name, got, count); end
    @(posedge clk); #1;
    in_valid_v[idx]  = 1'b0;
    out_ready_v[idx] = 1'b0;
  endtask

  task automatic test_back_to_back();
    run_stream(0, 100, 1'b0, "b2b_l1");
    run_stream(4, 20, 1'b0, "b2b_l16");
  endtask

  task automatic test_chained();
    run_stream(2, 100, 1'b1, "chain_l4");
  endtask

  initial begin
    rst = 1'b1;
    din = '0;
    in_valid_v  = '0;
    out_ready_v = '0;
    build_model();
    #2;
    test_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    test_known_vector();
    test_uniform();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    test_chained();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
